alu_exec32: RTL and testbench
=============================

// Module: alu_exec32
// PURPOSE
//  Execute stage directly downstream of the ALU decode unit. Consumes the decoded one-hot
//  ALU op plus two 32-bit operands and produces a registered result. Uses a valid/ready
//  handshake on both sides. Shifts are iterative (1 bit/cycle) unless the barrel shifter
//  is compiled in.
// PARAMETERS
//  XLEN   32  operand/result width (only 32 supported; shamt = in_b[4:0])
//  TAG_W  5   width of sideband tag (destination reg index), passed through unchanged
// PORTS
//  clk         in   1      clock, all state on rising edge
//  rst_n       in   1      asynchronous active-low reset
//  in_valid    in   1      op/operands/tag valid
//  in_ready    out  1      stage accepts input this cycle
//  in_op       in   11     one-hot ALU op from decoder (bit index = alu code)
//  in_a        in   XLEN   operand A (rs1)
//  in_b        in   XLEN   operand B (rs2 or imm); [4:0] = shift amount
//  in_tag      in   TAG_W  sideband tag
//  out_valid   out  1      result valid
//  out_ready   in   1      consumer accepts result
//  out_result  out  XLEN   registered result
//  out_tag     out  TAG_W  tag of the op that produced out_result
//  out_err     out  1      op vector was not one-hot (result forced 0)
//  busy        out  1      multi-cycle shift in progress
// BEHAVIOUR
//  - Op bits: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu,
//    10 passb (result = in_b, used for lui). Arithmetic modulo 2^32; slt/sltu -> {31'b0,lt}.
//  - Reset: state IDLE, out_valid=0, out_result=0, out_tag=0, out_err=0, busy=0.
//  - Handshake: input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
//    in_ready = (state==IDLE) && (!out_valid || out_ready) -> back-to-back 1 op/cycle.
//    While out_valid&&!out_ready, out_result/out_tag/out_err hold stable.
//  - FSM: IDLE -> (accept non-shift, shift with shamt==0, or illegal op) result registered,
//    out_valid=1 next cycle, stay IDLE (latency 1).
//    IDLE -> (accept sll/srl/sra, shamt!=0) SHIFT: busy=1, a copy shifted 1 bit/cycle,
//    counter loaded with shamt, decremented per cycle.
//    SHIFT -> counter reaches 1 -> DONE on that edge with result loaded.
//    DONE -> out_valid=1, busy=0; DONE -> IDLE on output transfer. Latency shift = shamt+1 cycles.
//  - sra fills with original bit 31 each step; srl/sll fill 0. shamt 31 with sra of 0x80000000
//    -> 0xFFFFFFFF.
//  - Illegal op (zero or multi-hot): out_err=1, out_result=0, latency 1, no shift started.
//  - in_valid while not in_ready: input ignored, upstream must hold.
//  - Reset asserted mid-shift: abort immediately, all outputs to reset values, no result emitted.
// CONFIGURATION
//  FAST_SHIFT_EN defined: shifts use a single-cycle barrel shifter; SHIFT/DONE states unused,
//    busy tied 0, every op latency 1.
//  FAST_SHIFT_EN undefined: iterative shifter as above (smaller area).
// STRUCTURE
//  - Shared package alu_pkg: ALU_OP_W=11, op bit index constants (ALU_ADD..ALU_PASSB),
//    FSM state encoding (IDLE/SHIFT/DONE).
//  - One sub-module: alu_shift_iter (iterative shifter + counter, start/done handshake);
//    omitted when FAST_SHIFT_EN is defined.
// TESTING
//  1. add a=0xFFFFFFFF b=1 tag=3, out_ready=1 -> next cycle out_valid, result 0, tag 3, err 0.
//  2. sub/slt/sltu a=1 b=0xFFFFFFFF back-to-back -> results 2, 0, 1 on 3 consecutive cycles,
//     in_ready held 1.
//  3. sra a=0x80000000 b=31 -> busy 31 cycles, in_ready=0, result 0xFFFFFFFF at cycle 32;
//     FAST_SHIFT_EN build: cycle 1.
//  4. out_ready=0 for 5 cycles after xor a=0xF0 b=0xFF -> 0x0F held stable, in_ready=0; result
//     transfers when out_ready=1.
//  5. in_op=11'b0 and 11'b00000000011 -> out_err=1, result 0, latency 1.
//  6. rst_n low at shift cycle 4 of sll b=20 -> out_valid/busy 0 immediately; after release,
//     new add accepted normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op bit indices, FSM and shifter encodings, one-hot check.
package alu_pkg;

    localparam int ALU_OP_W = 11;

    // Bit index of each op in the one-hot op vector
    localparam int ALU_ADD   = 0;
    localparam int ALU_SUB   = 1;
    localparam int ALU_AND   = 2;
    localparam int ALU_OR    = 3;
    localparam int ALU_XOR   = 4;
    localparam int ALU_SLL   = 5;
    localparam int ALU_SRL   = 6;
    localparam int ALU_SRA   = 7;
    localparam int ALU_SLT   = 8;
    localparam int ALU_SLTU  = 9;
    localparam int ALU_PASSB = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_t;

    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_SRA = 2'd2
    } sh_kind_t;

    // True when exactly one op bit is set
    function automatic logic is_onehot(input logic [ALU_OP_W-1:0] v);
        return (v != '0) && ((v & (v - ALU_OP_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// Iterative 1-bit/cycle shifter. A start pulse loads operand, kind and count;
// done is asserted in the cycle whose edge performs the final step, with
// result showing the fully shifted value at that moment.
module alu_shift_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  sh_kind_t        kind,
    input  logic [XLEN-1:0] data,
    input  logic [4:0]      shamt,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    sh_kind_t        kind_q;
    logic [4:0]      cnt;
    logic [XLEN-1:0] data_q;
    logic [XLEN-1:0] step;

    // One-bit shift of the working copy; sra keeps replicating the sign bit
    always_comb begin
        step = data_q >> 1;
        case (kind_q)
            SH_SLL:  step = data_q << 1;
            SH_SRL:  step = data_q >> 1;
            SH_SRA:  step = {data_q[XLEN-1], data_q[XLEN-1:1]};
            default: step = data_q >> 1;
        endcase
    end

    assign done   = busy && (cnt == 5'd1);
    assign result = step;

    // Load on start, then shift and count down until the last step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            cnt    <= '0;
            data_q <= '0;
            kind_q <= SH_SLL;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= shamt;
            data_q <= data;
            kind_q <= kind;
        end else if (busy) begin
            data_q <= step;
            cnt    <= cnt - 5'd1;
            if (cnt == 5'd1)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_exec32.sv
// ALU execute stage: one-hot op + operands in, registered result out,
// valid/ready on both sides. Non-shift ops take one cycle; shifts iterate
// one bit per cycle unless FAST_SHIFT_EN is defined (single-cycle barrel
// shifter, no multi-cycle states, busy tied low).
module alu_exec32
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ALU_OP_W-1:0] in_op,
    input  logic [XLEN-1:0]     in_a,
    input  logic [XLEN-1:0]     in_b,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_result,
    output logic [TAG_W-1:0]    out_tag,
    output logic                out_err,
    output logic                busy
);

    alu_state_t      state;
    logic [4:0]      shamt;
    logic            legal;
    logic            accept;
    logic            long_shift;
    logic            sh_done;
    logic            sh_busy;
    logic [XLEN-1:0] sh_res;
    logic [XLEN-1:0] alu_res;

    assign shamt    = in_b[4:0];
    assign legal    = is_onehot(in_op);
    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = sh_busy;

    // Single-cycle result; only meaningful for a legal one-hot op
    always_comb begin
        alu_res = '0;
        case (1'b1)
            in_op[ALU_ADD]:   alu_res = in_a + in_b;
            in_op[ALU_SUB]:   alu_res = in_a - in_b;
            in_op[ALU_AND]:   alu_res = in_a & in_b;
            in_op[ALU_OR]:    alu_res = in_a | in_b;
            in_op[ALU_XOR]:   alu_res = in_a ^ in_b;
`ifdef FAST_SHIFT_EN
            in_op[ALU_SLL]:   alu_res = in_a << shamt;
            in_op[ALU_SRL]:   alu_res = in_a >> shamt;
            in_op[ALU_SRA]:   alu_res = XLEN'($signed(in_a) >>> shamt);
`else
            // Only reached with shamt == 0: the operand passes through
            in_op[ALU_SLL],
            in_op[ALU_SRL],
            in_op[ALU_SRA]:   alu_res = in_a;
`endif
            in_op[ALU_SLT]:   alu_res = {{(XLEN-1){1'b0}}, $signed(in_a) < $signed(in_b)};
            in_op[ALU_SLTU]:  alu_res = {{(XLEN-1){1'b0}}, in_a < in_b};
            in_op[ALU_PASSB]: alu_res = in_b;
            default:          alu_res = '0;
        endcase
    end

`ifdef FAST_SHIFT_EN
    assign long_shift = 1'b0;
    assign sh_done    = 1'b0;
    assign sh_busy    = 1'b0;
    assign sh_res     = '0;
`else
    logic     is_shift;
    sh_kind_t sh_kind;

    assign is_shift   = in_op[ALU_SLL] | in_op[ALU_SRL] | in_op[ALU_SRA];
    assign long_shift = legal && is_shift && (shamt != 5'd0);

    // Select shift direction/fill for the iterative unit
    always_comb begin
        sh_kind = SH_SRA;
        if (in_op[ALU_SLL])
            sh_kind = SH_SLL;
        else if (in_op[ALU_SRL])
            sh_kind = SH_SRL;
    end

    alu_shift_iter #(.XLEN(XLEN)) u_shift (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept && long_shift),
        .kind   (sh_kind),
        .data   (in_a),
        .shamt  (shamt),
        .busy   (sh_busy),
        .done   (sh_done),
        .result (sh_res)
    );
`endif

    // Stage FSM with registered outputs; outputs only change on an accept,
    // a shift completion, or an output transfer, so they hold under stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            out_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        out_tag <= in_tag;
                        if (long_shift) begin
                            state     <= SHIFT;
                            out_valid <= 1'b0;
                            out_err   <= 1'b0;
                        end else begin
                            out_valid  <= 1'b1;
                            out_result <= legal ? alu_res : '0;
                            out_err    <= !legal;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (sh_done) begin
                        state      <= DONE;
                        out_valid  <= 1'b1;
                        out_result <= sh_res;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec32.sv
// Self-checking bench for alu_exec32: directed cases plus randomized traffic
// with random backpressure, scored against a behavioural op model.
module tb_alu_exec32;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        out_err;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;

    alu_exec32 #(.XLEN(32), .TAG_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_err    (out_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Model: returns {err, tag, result}
    function automatic logic [37:0] model(input logic [10:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] tag);
        longint ua = a;
        longint ub = b;
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint p2 = longint'(1) << b[4:0];
        logic [31:0] r = 32'd0;
        int idx = 0;
        if ($countones(op) != 1)
            return {1'b1, tag, 32'd0};
        for (int i = 0; i < 11; i++)
            if (op[i]) idx = i;
        case (idx)
            0:  r = 32'(ua + ub);
            1:  r = 32'(ua - ub);
            2:  r = a & b;
            3:  r = a | b;
            4:  r = a ^ b;
            5:  r = 32'(ua * p2);
            6:  r = 32'(ua / p2);
            7:  r = a[31] ? ~((~a) >> b[4:0]) : (a >> b[4:0]);
            8:  r = (sa < sb) ? 32'd1 : 32'd0;
            9:  r = (ua < ub) ? 32'd1 : 32'd0;
            default: r = b;
        endcase
        return {1'b0, tag, r};
    endfunction

    function automatic int exp_lat(input logic [10:0] op, input logic [31:0] b);
`ifdef FAST_SHIFT_EN
        return 1;
`else
        if ($countones(op) == 1 && (op[5] || op[6] || op[7]) && b[4:0] != 5'd0)
            return int'(b[4:0]) + 1;
        return 1;
`endif
    endfunction

    // Issue one op with out_ready high; check latency, busy span, in_ready
    // during the wait, and the result. Starts and ends at a negedge.
    task automatic do_op(input string nm, input logic [10:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag);
        int cyc;
        int bcyc;
        int rdy;
        int lat;
        lat = exp_lat(op, b);
        in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
        cyc = 0;
        while (!in_ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 200) chk({nm, " accept timeout"}, 64'(cyc), 64'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1; bcyc = 0; rdy = 0;
        while (!out_valid && cyc < 200) begin
            if (busy) bcyc++;
            if (in_ready) rdy++;
            @(negedge clk);
            cyc++;
        end
        chk({nm, " latency"}, 64'(cyc), 64'(lat));
        chk({nm, " busy cycles"}, 64'(bcyc), 64'(lat - 1));
        chk({nm, " in_ready while busy"}, 64'(rdy), 64'd0);
        chk({nm, " result"}, 64'({out_err, out_tag, out_result}), 64'(model(op, a, b, tag)));
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("drain timeout", 64'(n), 64'd0);
    endtask

    logic [37:0] exp_q[$];

    initial begin
        logic [37:0] e;
        logic [37:0] hold_val;
        logic        hold_prev;
        logic        acc;
        int          sent;
        int          cyc;

        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset outputs", 64'({out_valid, busy, out_err, out_tag, out_result}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle in_ready", 64'(in_ready), 64'd1);

        // add wraps to zero
        do_op("add wrap", 11'b1 << 0, 32'hFFFF_FFFF, 32'd1, 5'd3);

        // sub/slt/sltu back to back, one per cycle
        drain();
        in_a = 32'd1; in_b = 32'hFFFF_FFFF; in_tag = 5'd7; in_valid = 1'b1;
        in_op = 11'b1 << 1;
        chk("b2b ready0", 64'(in_ready), 64'd1);
        @(posedge clk); @(negedge clk);
        chk("b2b sub", 64'({out_valid, out_result}), {31'd0, 1'b1, 32'd2});
        in_op = 11'b1 << 8;
        chk("b2b ready1", 64'(in_ready), 64'd1);
        @(posedge clk); @(negedge clk);
        chk("b2b slt", 64'({out_valid, out_result}), {31'd0, 1'b1, 32'd0});
        in_op = 11'b1 << 9;
        chk("b2b ready2", 64'(in_ready), 64'd1);
        @(posedge clk); @(negedge clk);
        chk("b2b sltu", 64'({out_valid, out_result}), {31'd0, 1'b1, 32'd1});
        in_valid = 1'b0;

        // longest sra
        drain();
        do_op("sra 31", 11'b1 << 7, 32'h8000_0000, 32'd31, 5'd9);
        do_op("sll 0", 11'b1 << 5, 32'h1234_5678, 32'd0, 5'd1);
        do_op("srl 1", 11'b1 << 6, 32'h8000_0001, 32'd1, 5'd2);
        do_op("passb", 11'b1 << 10, 32'hDEAD_BEEF, 32'hABCD_E000, 5'd4);

        // stall with out_ready low
        drain();
        out_ready = 1'b0;
        in_op = 11'b1 << 4; in_a = 32'hF0; in_b = 32'hFF; in_tag = 5'd5; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall hold", 64'({out_valid, in_ready, out_tag, out_result}),
                64'({1'b1, 1'b0, 5'd5, 32'h0F}));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall release", 64'(out_valid), 64'd0);

        // illegal ops
        do_op("illegal zero", 11'b0, 32'h55, 32'h66, 5'd10);
        do_op("illegal multi", 11'b00000000011, 32'h55, 32'h66, 5'd11);

        // reset in the middle of a shift
        drain();
        in_op = 11'b1 << 5; in_a = 32'h1; in_b = 32'd20; in_tag = 5'd12; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
`ifndef FAST_SHIFT_EN
        chk("mid shift busy", 64'({busy, out_valid}), 64'({1'b1, 1'b0}));
`endif
        rst_n = 1'b0;
        #1;
        chk("mid shift reset", 64'({out_valid, busy, out_err, out_tag, out_result}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post reset quiet", 64'({out_valid, busy}), 64'd0);
        do_op("add after reset", 11'b1 << 0, 32'd100, 32'd23, 5'd13);

        // randomized traffic with backpressure
        drain();
        @(negedge clk);
        sent = 0; cyc = 0; acc = 1'b0; hold_prev = 1'b0; hold_val = '0;
        while ((sent < 80 || exp_q.size() != 0 || in_valid) && cyc < 20000) begin
            if (acc) begin
                in_valid = 1'b0;
                acc = 1'b0;
            end
            if (!in_valid && sent < 80 && $urandom_range(0, 3) != 0) begin
                if ($urandom_range(0, 7) == 0)
                    in_op = 11'($urandom);
                else
                    in_op = 11'b1 << $urandom_range(0, 10);
                in_a   = $urandom;
                in_b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
                in_tag = 5'($urandom);
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (hold_prev)
                chk("rand hold", 64'({out_valid, out_err, out_tag, out_result}), 64'({1'b1, hold_val}));
            hold_prev = out_valid && !out_ready;
            hold_val  = {out_err, out_tag, out_result};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rand unexpected output", 64'(out_result), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rand result", 64'({out_err, out_tag, out_result}), 64'(e));
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_op, in_a, in_b, in_tag));
                sent++;
                acc = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        chk("rand all sent", 64'(sent), 64'd80);
        chk("rand drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
